// File: rtl/encoder_pkg.sv
// Shared constants for the quadrature encoder reader: read-byte codes,
// quadrature phase encodings, data widths and the phase-index helper.
package encoder_pkg;

  localparam int unsigned N_MOTORS = 4;
  localparam int unsigned POS_W    = 16;
  localparam int unsigned SPD_W    = 8;

  localparam logic [1:0] BYTE_POS_LO = 2'd0;
  localparam logic [1:0] BYTE_POS_HI = 2'd1;
  localparam logic [1:0] BYTE_SPEED  = 2'd2;
  localparam logic [1:0] BYTE_STATUS = 2'd3;

  // {A,B} levels in forward rotation order
  localparam logic [1:0] QS_0 = 2'b00;
  localparam logic [1:0] QS_1 = 2'b01;
  localparam logic [1:0] QS_2 = 2'b11;
  localparam logic [1:0] QS_3 = 2'b10;

  // Position of an {A,B} level in the forward cycle; differences mod 4 give the step
  function automatic logic [1:0] quad_phase(input logic [1:0] ab);
    logic [1:0] ph;
    ph = 2'd0;
    case (ab)
      QS_0:    ph = 2'd0;
      QS_1:    ph = 2'd1;
      QS_2:    ph = 2'd2;
      QS_3:    ph = 2'd3;
      default: ph = 2'd0;
    endcase
    return ph;
  endfunction

endpackage

// File: rtl/encoder_reader_if.sv
// Processor-side bus of the encoder reader: raw encoder pins, read/clear
// controls from the PicoBlaze and the measured-motion outputs.
interface encoder_reader_if;
  import encoder_pkg::*;

  logic [2*N_MOTORS-1:0] encoders;
  logic [1:0]            motor_select;
  logic [1:0]            byte_select;
  logic                  read_strobe;
  logic                  clear_pos;
  logic [7:0]            data_out;
  logic [N_MOTORS-1:0]   direction;
  logic                  speed_valid;

  modport master (
    output encoders, motor_select, byte_select, read_strobe, clear_pos,
    input  data_out, direction, speed_valid
  );

  modport slave (
    input  encoders, motor_select, byte_select, read_strobe, clear_pos,
    output data_out, direction, speed_valid
  );

endinterface

// File: rtl/quad_channel.sv
// One encoder channel: synchroniser, glitch filter, x4 quadrature decode,
// position counter, direction flag and per-window speed accumulator.
module quad_channel
  import encoder_pkg::*;
#(
  parameter int unsigned FILTER_LEN = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [1:0]       i_ab,
  input  logic             i_clear,
  input  logic             i_window_end,
  output logic [POS_W-1:0] o_pos,
  output logic [SPD_W-1:0] o_speed,
  output logic             o_dir,
  output logic             o_illegal_c
);

  logic [1:0]                 r_sync;
  logic [1:0][FILTER_LEN-1:0] r_hist;
  logic [1:0]                 r_filt;
  logic [1:0]                 w_filt_nxt;
  logic [1:0]                 w_delta;
  logic                       w_inc;
  logic                       w_dec;
  logic                       w_step;
  logic [POS_W-1:0]           r_pos;
  logic [SPD_W-1:0]           r_acc;
  logic [SPD_W-1:0]           r_speed;
  logic                       r_dir;

  // r_hist[p][0] is the second synchroniser stage; a level is accepted once the whole history agrees
  always_comb begin
    w_filt_nxt = r_filt;
    for (int p = 0; p < 2; p++) begin
      if (&r_hist[p])       w_filt_nxt[p] = 1'b1;
      else if (~|r_hist[p]) w_filt_nxt[p] = 1'b0;
    end
    w_delta     = quad_phase(w_filt_nxt) - quad_phase(r_filt);
    w_inc       = (w_delta == 2'd1);
    w_dec       = (w_delta == 2'd3);
    w_step      = w_inc | w_dec;
    o_illegal_c = (w_delta == 2'd2);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_sync  <= '0;
      r_hist  <= '0;
      r_filt  <= '0;
      r_pos   <= '0;
      r_dir   <= 1'b0;
      r_acc   <= '0;
      r_speed <= '0;
    end else begin
      r_sync <= i_ab;
      for (int p = 0; p < 2; p++) begin
        r_hist[p] <= {r_hist[p][FILTER_LEN-2:0], r_sync[p]};
      end
      r_filt <= w_filt_nxt;

      if (i_clear)    r_pos <= '0;
      else if (w_inc) r_pos <= r_pos + POS_W'(1);
      else if (w_dec) r_pos <= r_pos - POS_W'(1);

      if (w_inc)      r_dir <= 1'b1;
      else if (w_dec) r_dir <= 1'b0;

      // A step on the closing cycle is credited to the new window
      if (i_window_end) begin
        r_speed <= r_acc;
        r_acc   <= SPD_W'(w_step);
      end else if (w_step && (r_acc != '1)) begin
        r_acc <= r_acc + SPD_W'(1);
      end
    end
  end

  assign o_pos   = r_pos;
  assign o_speed = r_speed;
  assign o_dir   = r_dir;

endmodule

// File: rtl/encoder_reader.sv
// Four-motor quadrature encoder reader: tick/window timing, coherent 16-bit
// position reads via shadow registers, sticky error flags and the read mux.
module encoder_reader
  import encoder_pkg::*;
#(
  parameter int unsigned CLK_DIV      = 250,
  parameter int unsigned SAMPLE_TICKS = 4000,
  parameter int unsigned FILTER_LEN   = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  encoder_reader_if.slave   bus
);

  localparam int unsigned DIV_W = $clog2(CLK_DIV);
  localparam int unsigned WIN_W = $clog2(SAMPLE_TICKS);

  logic [DIV_W-1:0]                r_div;
  logic [WIN_W-1:0]                r_win;
  logic                            w_tick;
  logic                            w_window_end;
  logic [N_MOTORS-1:0][POS_W-1:0]  w_pos;
  logic [N_MOTORS-1:0][SPD_W-1:0]  w_speed;
  logic [N_MOTORS-1:0]             w_dir;
  logic [N_MOTORS-1:0]             w_illegal;
  logic [N_MOTORS-1:0]             r_err;
  logic [N_MOTORS-1:0][7:0]        r_shadow;
  logic [7:0]                      w_rd_data;
  logic [7:0]                      r_data;
  logic                            r_speed_valid;
  logic                            w_rd_lo;
  logic                            w_rd_status;

  assign w_tick       = (r_div == DIV_W'(CLK_DIV - 1));
  assign w_window_end = w_tick && (r_win == WIN_W'(SAMPLE_TICKS - 1));
  assign w_rd_lo      = bus.read_strobe && (bus.byte_select == BYTE_POS_LO);
  assign w_rd_status  = bus.read_strobe && (bus.byte_select == BYTE_STATUS);

  for (genvar k = 0; k < N_MOTORS; k++) begin : g_ch
    quad_channel #(.FILTER_LEN(FILTER_LEN)) u_ch (
      .clk          (clk),
      .reset_n      (reset_n),
      .i_ab         ({bus.encoders[2*k], bus.encoders[2*k+1]}),
      .i_clear      (bus.clear_pos && (bus.motor_select == 2'(k))),
      .i_window_end (w_window_end),
      .o_pos        (w_pos[k]),
      .o_speed      (w_speed[k]),
      .o_dir        (w_dir[k]),
      .o_illegal_c  (w_illegal[k])
    );
  end

  // High byte is always served from the shadow captured by the low-byte read
  always_comb begin
    w_rd_data = '0;
    case (bus.byte_select)
      BYTE_POS_LO: w_rd_data = w_pos[bus.motor_select][7:0];
      BYTE_POS_HI: w_rd_data = r_shadow[bus.motor_select];
      BYTE_SPEED:  w_rd_data = w_speed[bus.motor_select];
      BYTE_STATUS: w_rd_data = {r_err[bus.motor_select], w_dir[bus.motor_select], 6'b0};
      default:     w_rd_data = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_div         <= '0;
      r_win         <= '0;
      r_speed_valid <= 1'b0;
      r_data        <= '0;
      r_shadow      <= '0;
      r_err         <= '0;
    end else begin
      if (w_tick) begin
        r_div <= '0;
        r_win <= w_window_end ? '0 : r_win + WIN_W'(1);
      end else begin
        r_div <= r_div + DIV_W'(1);
      end
      r_speed_valid <= w_window_end;
      r_data        <= w_rd_data;

      if (w_rd_lo) r_shadow[bus.motor_select] <= w_pos[bus.motor_select][POS_W-1 -: 8];

      // A fresh illegal transition outranks a status-read clear
      for (int k = 0; k < N_MOTORS; k++) begin
        if (w_illegal[k])                                          r_err[k] <= 1'b1;
        else if (w_rd_status && (bus.motor_select == 2'(k)))       r_err[k] <= 1'b0;
      end
    end
  end

  assign bus.data_out    = r_data;
  assign bus.direction   = w_dir;
  assign bus.speed_valid = r_speed_valid;

endmodule

// File: tb/tb_encoder_reader.sv
// Randomised self-checking bench for encoder_reader against a step-level
// reference model (positions, directions, errors, step timestamps per window).
module tb_encoder_reader;

  localparam int CD  = 10;
  localparam int ST  = 200;
  localparam int FL  = 4;
  localparam int W   = CD * ST;
  localparam int LAT = 2 + FL;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  encoder_reader_if bus();

  encoder_reader #(.CLK_DIV(CD), .SAMPLE_TICKS(ST), .FILTER_LEN(FL)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  int checks = 0;
  int fails  = 0;
  int cyc;
  int sv_cnt = 0;

  logic [15:0] m_pos    [4];
  logic        m_dir    [4];
  logic        m_err    [4];
  logic [7:0]  m_shadow [4];
  int          m_idx    [4];
  int          stamps   [4][0:2047];
  int          nst      [4];
  logic [7:0]  enc;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // Edge counter since reset release: the n-th rising edge leaves cyc == n
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) cyc <= 0;
    else          cyc <= cyc + 1;
  end

  always @(negedge clk) begin
    if (reset_n) begin
      if (bus.speed_valid) sv_cnt++;
      if (bus.speed_valid || (cyc > 0 && (cyc % W) == 0))
        chk("speed_valid_timing", 32'(bus.speed_valid), 32'((cyc > 0 && (cyc % W) == 0)));
    end
  end

  function automatic logic [1:0] code_of(input int idx);
    case (idx)
      0:       return 2'b00;
      1:       return 2'b01;
      2:       return 2'b11;
      default: return 2'b10;
    endcase
  endfunction

  // Speed visible at capture edge cap: steps stamped in the window closed at the last end before cap
  function automatic int exp_speed(input int k, input int cap);
    int e, n;
    e = ((cap - 1) / W) * W;
    n = 0;
    if (e == 0) return 0;
    for (int i = 0; i < nst[k]; i++)
      if (stamps[k][i] >= e - W && stamps[k][i] < e) n++;
    return (n > 255) ? 255 : n;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 4; k++) begin
      m_pos[k] = '0; m_dir[k] = 1'b0; m_err[k] = 1'b0; m_shadow[k] = '0;
      m_idx[k] = 0; nst[k] = 0;
    end
  endtask

  task automatic set_pins(input int k);
    logic [1:0] c;
    c = code_of(m_idx[k]);
    enc[2*k]     = c[1];
    enc[2*k+1]   = c[0];
    bus.encoders = enc;
  endtask

  task automatic step(input int k, input bit fwd, input int hold);
    m_idx[k] = (m_idx[k] + (fwd ? 1 : 3)) % 4;
    set_pins(k);
    stamps[k][nst[k]] = cyc + LAT;
    nst[k]++;
    m_pos[k] = fwd ? 16'(m_pos[k] + 16'd1) : 16'(m_pos[k] - 16'd1);
    m_dir[k] = fwd;
    repeat (hold) @(negedge clk);
  endtask

  task automatic glitch(input int k, input int pin, input int len);
    enc[2*k+pin] = ~enc[2*k+pin];
    bus.encoders = enc;
    repeat (len) @(negedge clk);
    enc[2*k+pin] = ~enc[2*k+pin];
    bus.encoders = enc;
    repeat (FL + 2) @(negedge clk);
  endtask

  task automatic jump(input int k);
    m_idx[k] = (m_idx[k] + 2) % 4;
    set_pins(k);
    m_err[k] = 1'b1;
    repeat (8) @(negedge clk);
  endtask

  task automatic clr(input int k);
    bus.motor_select = 2'(k);
    bus.clear_pos    = 1'b1;
    @(negedge clk);
    bus.clear_pos    = 1'b0;
    m_pos[k]         = '0;
  endtask

  task automatic settle();
    repeat (FL + 4) @(negedge clk);
  endtask

  task automatic rd(input int k, input logic [1:0] b, output logic [7:0] d, output int cap);
    bus.motor_select = 2'(k);
    bus.byte_select  = b;
    bus.read_strobe  = 1'b1;
    @(negedge clk);
    cap             = cyc;
    d               = bus.data_out;
    bus.read_strobe = 1'b0;
  endtask

  task automatic chk_rd(input string tag, input int k, input logic [1:0] b);
    logic [7:0] d, e;
    int cap;
    rd(k, b, d, cap);
    case (b)
      2'd0: begin e = m_pos[k][7:0]; m_shadow[k] = m_pos[k][15:8]; end
      2'd1: e = m_shadow[k];
      2'd2: e = 8'(exp_speed(k, cap));
      default: begin e = {m_err[k], m_dir[k], 6'b0}; m_err[k] = 1'b0; end
    endcase
    chk($sformatf("%s_m%0d_b%0d", tag, k, b), 32'(d), 32'(e));
  endtask

  task automatic chk_dir(input string tag);
    chk(tag, 32'(bus.direction), 32'({m_dir[3], m_dir[2], m_dir[1], m_dir[0]}));
  endtask

  initial begin
    int e, sv0, got;
    bit seen;
    enc = '0;
    bus.encoders = '0; bus.motor_select = '0; bus.byte_select = '0;
    bus.read_strobe = 1'b0; bus.clear_pos = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    reset_n = 1'b1;

    chk("rst_data_out", 32'(bus.data_out), 32'd0);
    chk("rst_direction", 32'(bus.direction), 32'd0);
    chk("rst_speed_valid", 32'(bus.speed_valid), 32'd0);

    // Forward counting on motor 0
    for (int i = 0; i < 8; i++) step(0, 1'b1, 10);
    settle();
    chk_rd("fwd8", 0, 2'd0);
    chk_dir("fwd8_dir");
    chk_rd("fwd8", 0, 2'd3);
    chk_rd("fwd8_other", 1, 2'd0);

    // Reverse wrap on motor 1
    step(1, 1'b0, 10);
    settle();
    chk_rd("rev_wrap", 1, 2'd0);
    chk_rd("rev_wrap", 1, 2'd1);

    // Glitch rejection and illegal jump on motor 2
    glitch(2, 0, 2);
    settle();
    chk_rd("glitch", 2, 2'd0);
    jump(2);
    settle();
    chk_rd("illegal", 2, 2'd0);
    chk_rd("illegal", 2, 2'd3);
    chk_rd("err_cleared", 2, 2'd3);

    // Speed saturation, single speed_valid per window, boundary step credited to next window
    while ((cyc % W) != 10) @(negedge clk);
    sv0 = sv_cnt;
    for (int i = 0; i < 300; i++) step(3, 1'b1, 6);
    e = (cyc / W + 1) * W;
    while (cyc < e - LAT) @(negedge clk);
    step(3, 1'b1, 8);
    chk("sv_once_per_window", 32'(sv_cnt - sv0), 32'd1);
    chk_rd("speed_sat", 3, 2'd2);
    chk_rd("pos_many", 3, 2'd0);
    while (cyc < e + W + 2) @(negedge clk);
    chk_rd("speed_boundary", 3, 2'd2);

    // Clear colliding with a step, then shadow coherence
    step(0, 1'b1, LAT - 1);
    clr(0);
    settle();
    chk_rd("clear_wins", 0, 2'd0);
    chk_dir("clear_dir");
    step(0, 1'b0, 8);
    settle();
    chk_rd("shadow_old", 0, 2'd1);
    chk_rd("shadow_new", 0, 2'd0);
    chk_rd("shadow_new", 0, 2'd1);

    // Random steps and glitches on all motors
    for (int n = 0; n < 60; n++) begin
      int k, op;
      k  = $urandom_range(0, 3);
      op = $urandom_range(0, 4);
      if (op < 4) step(k, op[0], 6 + $urandom_range(0, 3));
      else        glitch(k, $urandom_range(0, 1), $urandom_range(1, FL - 1));
    end
    settle();
    for (int k = 0; k < 4; k++) begin
      chk_rd("rnd", k, 2'd0);
      chk_rd("rnd", k, 2'd1);
      chk_rd("rnd", k, 2'd3);
      chk_rd("rnd", k, 2'd2);
    end
    chk_dir("rnd_dir");

    // Asynchronous reset mid-window
    clr(0);
    for (int i = 0; i < 5; i++) step(0, 1'b1, 6);
    settle();
    chk_rd("pre_reset", 0, 2'd0);
    @(posedge clk);
    #3;
    reset_n = 1'b0;
    enc = '0;
    bus.encoders = enc;
    #1;
    chk("async_rst_data_out", 32'(bus.data_out), 32'd0);
    chk("async_rst_direction", 32'(bus.direction), 32'd0);
    chk("async_rst_speed_valid", 32'(bus.speed_valid), 32'd0);
    model_reset();
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    seen = 1'b0;
    got  = 0;
    for (int i = 0; i < 2 * W && !seen; i++) begin
      @(negedge clk);
      if (bus.speed_valid) begin seen = 1'b1; got = cyc; end
    end
    chk("first_sv_after_reset", 32'(got), 32'(W));
    chk_rd("post_reset", 0, 2'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule
